multdiv_seq_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit for the execute stage of the 5-stage pipeline.
- The decode logic issues a one-cycle ctrl_MULT or ctrl_DIV pulse with operands.
- The unit computes over several cycles and returns the result with a one-cycle ready pulse.
- The pipeline stalls the DX latch while busy is high and writes data_result to rd (or the rstatus code on exception) when data_resultRDY fires.

---
 rtl/multdiv_seq_unit.sv | 165 ++++++++++++++++
 tb/tb_multdiv_seq_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq_unit.sv
// rtl/multdiv_seq_unit.sv - iterative signed multiply/divide unit for the execute stage
//
// Purpose: computes a signed WIDTH x WIDTH multiply (radix-2 Booth) or a signed
// divide (non-restoring on magnitudes, truncating toward zero). It takes one
// setup cycle and then WIDTH iteration cycles, and returns the result with a
// one-cycle ready pulse.
//
// Ports:
//   clock          - master clock, rising edge
//   reset          - synchronous active-low reset
//   data_operandA  - multiplicand / dividend (two's complement)
//   data_operandB  - multiplier / divisor (two's complement)
//   ctrl_MULT      - start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV       - start-divide pulse
//   data_result    - product low word or quotient, held between ready pulses
//   data_exception - multiply overflow or divide exception, valid with result
//   data_resultRDY - one-cycle result-valid pulse
//   busy           - operation in flight
module multdiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_prep;
  // Booth register {acc, multiplier, q-1}; acc carries one guard bit so that
  // subtracting INT_MIN cannot overflow the accumulator.
  logic [2*WIDTH+1:0] r_prod;
  // Partial remainder spans [-2V, 2V), so it needs two bits above WIDTH.
  logic [WIDTH+1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo, r_dvs;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  logic               w_start, w_iter, w_last;
  logic [WIDTH:0]     w_mcand, w_acc_nxt, w_ovf_bits;
  logic [2*WIDTH+1:0] w_prod_nxt;
  logic               w_mul_ovf;
  logic [WIDTH+1:0]   w_dvs_ext, w_rem_sh, w_rem_nxt, w_rem_fix;
  logic [WIDTH-1:0]   w_quo_nxt, w_quo_signed, w_mag_a, w_mag_b;
  logic               w_div_zero, w_div_ovf;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_iter  = ((r_state == S_MUL) || (r_state == S_DIV)) && !r_prep;
  assign w_last  = w_iter && (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
      S_DONE:       w_state_nxt = S_IDLE;
      default:      ;
    endcase
    // A new start aborts whatever is in flight.
    if (ctrl_MULT)     w_state_nxt = S_MUL;
    else if (ctrl_DIV) w_state_nxt = S_DIV;
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Booth step: add/sub multiplicand per {q0, q-1}, then arithmetic shift right.
  assign w_mcand = {r_a[WIDTH-1], r_a};
  always_comb begin
    w_acc_nxt = r_prod[2*WIDTH+1:WIDTH+1];
    case (r_prod[1:0])
      2'b01:   w_acc_nxt = r_prod[2*WIDTH+1:WIDTH+1] + w_mcand;
      2'b10:   w_acc_nxt = r_prod[2*WIDTH+1:WIDTH+1] - w_mcand;
      default: ;
    endcase
  end
  assign w_prod_nxt = $signed({w_acc_nxt, r_prod[WIDTH:0]}) >>> 1;
  // Product bits [2W-1:W-1] must all match for the low word to be exact.
  assign w_ovf_bits = w_prod_nxt[2*WIDTH:WIDTH];
  assign w_mul_ovf  = !((&w_ovf_bits) || (~|w_ovf_bits));

  // Non-restoring step on magnitudes; quotient bits are final as produced.
  assign w_mag_a      = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_mag_b      = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_dvs_ext    = {2'b00, r_dvs};
  assign w_rem_sh     = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
  assign w_rem_nxt    = r_rem[WIDTH+1] ? (w_rem_sh + w_dvs_ext) : (w_rem_sh - w_dvs_ext);
  assign w_quo_nxt    = {r_quo[WIDTH-2:0], ~w_rem_nxt[WIDTH+1]};
  assign w_rem_fix    = w_rem_nxt[WIDTH+1] ? (w_rem_nxt + w_dvs_ext) : w_rem_nxt;
  assign w_quo_signed = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_quo_nxt : w_quo_nxt;
  assign w_div_zero   = (r_b == '0);
  assign w_div_ovf    = (r_a == INT_MIN) && (r_b == '1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_prep   <= 1'b0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_a    <= data_operandA;
      r_b    <= data_operandB;
      r_cnt  <= '0;
      r_prep <= 1'b1;
    end else if (r_prep) begin
      // Setup cycle: load iteration registers from the latched operands.
      r_prep <= 1'b0;
      r_prod <= {{(WIDTH+1){1'b0}}, r_b, 1'b0};
      r_rem  <= '0;
      r_quo  <= w_mag_a;
      r_dvs  <= w_mag_b;
    end else if (w_iter) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        if (w_last) begin
          r_result <= w_prod_nxt[WIDTH:1];
          r_exc    <= w_mul_ovf;
        end
      end else begin
        r_quo <= w_quo_nxt;
        r_rem <= w_last ? w_rem_fix : w_rem_nxt;
        if (w_last) begin
          if (w_div_zero) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end else if (w_div_ovf) begin
            r_result <= INT_MIN;
            r_exc    <= 1'b1;
          end else begin
            r_result <= w_quo_signed;
            r_exc    <= 1'b0;
          end
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_MUL) || (r_state == S_DIV);

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// tb/tb_multdiv_seq_unit.sv - self-checking bench for multdiv_seq_unit
module tb_multdiv_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        c_mul = 1'b0;
  logic        c_div = 1'b0;
  logic [31:0] res;
  logic        exc;
  logic        rdy;
  logic        bsy;

  int total = 0;
  int bad   = 0;

  multdiv_seq_unit #(.WIDTH(32)) dut (
    .clock(clk),
    .reset(rst_n),
    .data_operandA(op_a),
    .data_operandB(op_b),
    .ctrl_MULT(c_mul),
    .ctrl_DIV(c_div),
    .data_result(res),
    .data_exception(exc),
    .data_resultRDY(rdy),
    .busy(bsy)
  );

  always #5 clk = ~clk;

  // Reference: {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    if (is_mul) begin
      p = sa * sb;
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
    p = sa / sb;
    return {1'b0, p[31:0]};
  endfunction

  // Pulse a start at the next rising edge, then scramble the operand inputs.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; c_mul = m; c_div = d;
    @(posedge clk);
    #1;
    c_mul = 1'b0; c_div = 1'b0;
    op_a = $urandom; op_b = $urandom;
  endtask

  // Observe 45 cycles after a start edge: first RDY edge, busy and RDY cycle counts.
  task automatic wait_rdy(output int lat, output int busy_cyc, output int rdy_cyc);
    lat = -1; busy_cyc = 0; rdy_cyc = 0;
    for (int n = 0; n <= 45; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (bsy) busy_cyc++;
      if (rdy) begin
        rdy_cyc++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_result: got %h expected %h", res, 32'h0); end
    total++; if (exc !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b expected 0", exc); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bsy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [32:0] e;
    int lat, bc, rc;
    av[0] = 32'd6;        bv[0] = 32'd7;
    av[1] = 32'hFFFFFFFD; bv[1] = 32'd5;
    av[2] = 32'h00010000; bv[2] = 32'h00010000;
    av[3] = 32'h80000000; bv[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      e = model(1'b1, av[i], bv[i]);
      start_op(1'b1, 1'b0, av[i], bv[i]);
      wait_rdy(lat, bc, rc);
      total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
      total++; if (bc !== 33) begin bad++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected 33", i, bc); end
      total++; if (rc !== 1) begin bad++; $display("FAIL mul_rdy_cycles[%0d]: got %0d expected 1", i, rc); end
      total++; if (res !== e[31:0]) begin bad++; $display("FAIL mul_result[%0d] a=%h b=%h: got %h expected %h", i, av[i], bv[i], res, e[31:0]); end
      total++; if (exc !== e[32]) begin bad++; $display("FAIL mul_exc[%0d] a=%h b=%h: got %b expected %b", i, av[i], bv[i], exc, e[32]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [32:0] e;
    int lat, bc, rc;
    av[0] = 32'd100;      bv[0] = 32'hFFFFFFF9;
    av[1] = 32'hFFFFFF9C; bv[1] = 32'd7;
    av[2] = 32'd7;        bv[2] = 32'd100;
    av[3] = 32'd5;        bv[3] = 32'd0;
    av[4] = 32'h80000000; bv[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      e = model(1'b0, av[i], bv[i]);
      start_op(1'b0, 1'b1, av[i], bv[i]);
      wait_rdy(lat, bc, rc);
      total++; if (lat !== 33) begin bad++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
      total++; if (bc !== 33) begin bad++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 33", i, bc); end
      total++; if (rc !== 1) begin bad++; $display("FAIL div_rdy_cycles[%0d]: got %0d expected 1", i, rc); end
      total++; if (res !== e[31:0]) begin bad++; $display("FAIL div_result[%0d] a=%h b=%h: got %h expected %h", i, av[i], bv[i], res, e[31:0]); end
      total++; if (exc !== e[32]) begin bad++; $display("FAIL div_exc[%0d] a=%h b=%h: got %b expected %b", i, av[i], bv[i], exc, e[32]); end
    end
  endtask

  task automatic test_abort();
    int seen, lat, bc, rc;
    seen = 0;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
      if (rdy) seen++;
    end
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    wait_rdy(lat, bc, rc);
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_early_rdy: got %0d expected 0", seen); end
    total++; if (lat !== 33) begin bad++; $display("FAIL abort_latency: got %0d expected 33", lat); end
    total++; if (rc !== 1) begin bad++; $display("FAIL abort_rdy_cycles: got %0d expected 1", rc); end
    total++; if (res !== 32'd5) begin bad++; $display("FAIL abort_result: got %h expected %h", res, 32'd5); end
    total++; if (exc !== 1'b0) begin bad++; $display("FAIL abort_exc: got %b expected 0", exc); end
  endtask

  task automatic test_both_starts();
    int lat, bc, rc;
    start_op(1'b1, 1'b1, 32'd9, 32'd3);
    wait_rdy(lat, bc, rc);
    total++; if (lat !== 33) begin bad++; $display("FAIL both_latency: got %0d expected 33", lat); end
    total++; if (res !== 32'd27) begin bad++; $display("FAIL both_result: got %h expected %h", res, 32'd27); end
    total++; if (exc !== 1'b0) begin bad++; $display("FAIL both_exc: got %b expected 0", exc); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [32:0] e;
    bit is_mul;
    int lat, bc, rc;
    for (int i = 0; i < 30; i++) begin
      is_mul = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 20) * (($urandom_range(0, 1) == 1) ? -1 : 1);
        3:       b = $urandom_range(0, 65535);
        default: b = $urandom;
      endcase
      e = model(is_mul, a, b);
      start_op(is_mul, !is_mul, a, b);
      wait_rdy(lat, bc, rc);
      total++; if (lat !== 33 || rc !== 1) begin bad++; $display("FAIL rand_timing[%0d]: got lat=%0d rdy=%0d expected lat=33 rdy=1", i, lat, rc); end
      total++; if (res !== e[31:0]) begin bad++; $display("FAIL rand_result[%0d] mul=%0d a=%h b=%h: got %h expected %h", i, is_mul, a, b, res, e[31:0]); end
      total++; if (exc !== e[32]) begin bad++; $display("FAIL rand_exc[%0d] mul=%0d a=%h b=%h: got %b expected %b", i, is_mul, a, b, exc, e[32]); end
    end
  endtask

  task automatic test_reset_midop();
    int seen, nonzero;
    seen = 0; nonzero = 0;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b expected 0", bsy); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL midreset_rdy: got %b expected 0", rdy); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL midreset_result: got %h expected %h", res, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy) seen++;
      if (res !== 32'h0) nonzero++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_late_rdy: got %0d expected 0", seen); end
    total++; if (nonzero !== 0) begin bad++; $display("FAIL midreset_result_hold: got %0d nonzero cycles expected 0", nonzero); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_both_starts();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
